// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, rx_ctrl state encoding and the drop-counter limits.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int DROP_CNT_W  = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    CLEAR
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO: rd_data always shows the head entry.
// Pushes into a full FIFO are accepted only when a pop frees a slot on the same edge.
module uart_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_eff;
  logic             pop_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_50m) begin
    if (push_eff) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Captures receiver bytes into a FWFT FIFO, pulses rx_rdy_clr once per byte, flags overflow.
// Define UART_RX_CTRL_DROPCNT_EN to build the saturating dropped-byte counter.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_rdy_clr,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          count,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  rx_state_e state_reg, state_next;
  logic      rx_rdy_clr_reg, rx_rdy_clr_next;
  logic      capture;
  logic      fifo_full, fifo_empty;
  logic      push, pop, drop;
  logic      overrun_reg;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rx_rdy_clr_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rx_rdy_clr_reg <= rx_rdy_clr_next;
    end
  end

  // CLEAR ignores rx_rdy: the receiver only lowers rdy on the edge it sees rdy_clr.
  always_comb begin
    state_next      = state_reg;
    rx_rdy_clr_next = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_rdy) begin
          capture         = 1'b1;
          rx_rdy_clr_next = 1'b1;
          state_next      = CLEAR;
        end
      end
      CLEAR: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pop  = out_valid && out_ready;
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (rx_data),
    .pop     (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // A drop on the same edge as overrun_clr keeps the flag set.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
    end else if (overrun_clr) begin
      overrun_reg <= 1'b0;
    end
  end

`ifdef UART_RX_CTRL_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop) begin
      if (overrun_clr) begin
        drop_cnt_reg <= DROP_CNT_W'(1);
      end else if (drop_cnt_reg != DROP_CNT_MAX) begin
        drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
      end
    end else if (overrun_clr) begin
      drop_cnt_reg <= '0;
    end
  end

  assign drop_count = drop_cnt_reg;
`else
  assign drop_count = '0;
`endif

  assign rx_rdy_clr = rx_rdy_clr_reg;
  assign out_valid  = !fifo_empty;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised bench for uart_rx_ctrl against a queue-based model of the capture/FIFO/overflow rules.
// Honours UART_RX_CTRL_DROPCNT_EN for the drop_count expectation.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_50m = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rdy_clr;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overrun;
  logic          overrun_clr = 1'b0;
  logic [7:0]    drop_count;

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .rx_rdy_clr  (rx_rdy_clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .drop_count  (drop_count)
  );

  always #10 clk_50m = ~clk_50m;

  int total = 0;
  int bad   = 0;

  // Model state: stored bytes, whether the controller is in its post-capture cycle, flags.
  logic [7:0] m_q[$];
  logic [7:0] tx_q[$];
  bit         m_busy = 1'b0;
  bit         m_ovr  = 1'b0;
  int         m_dc   = 0;
  bit         gap_en = 1'b0;
  int         cyc    = 0;
  int         clr_cyc[$];
  logic [7:0] last_pop = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_dc();
`ifdef UART_RX_CTRL_DROPCNT_EN
    return m_dc;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_ovr  = 1'b0;
    m_dc   = 0;
  endtask

  // One clock: predict the edge, advance, compare, then let the receiver react.
  task automatic step();
    bit         acc, pp, dropped, clr_now;
    logic [7:0] b;
    clr_now = rx_rdy_clr;
    acc     = rx_rdy && !m_busy;
    pp      = out_ready && (m_q.size() != 0);
    dropped = 1'b0;
    b       = rx_data;
    if (pp) last_pop = m_q.pop_front();
    if (acc) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovr = 1'b1;
      m_dc  = overrun_clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
    end else if (overrun_clr) begin
      m_ovr = 1'b0;
      m_dc  = 0;
    end
    m_busy = acc;
    @(posedge clk_50m);
    #1;
    cyc++;
    if (acc) $display("cyc %0d rx byte %02h %s count=%0d", cyc, b, dropped ? "dropped" : "stored", m_q.size());
    if (pp) $display("cyc %0d pop byte %02h count=%0d", cyc, last_pop, m_q.size());
    if (rx_rdy_clr) clr_cyc.push_back(cyc);
    check("rdy_clr", 32'(rx_rdy_clr), 32'(acc));
    check("valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("count", 32'(count), 32'(m_q.size()));
    if (m_q.size() != 0) check("data", 32'(out_data), 32'(m_q[0]));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("drop_count", 32'(drop_count), 32'(exp_dc()));
    if (clr_now || !rx_rdy) begin
      if (tx_q.size() != 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
        rx_rdy  = 1'b1;
        rx_data = tx_q.pop_front();
      end else begin
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int limit);
    int k;
    k = 0;
    while ((tx_q.size() != 0 || rx_rdy || m_busy) && k < limit) begin
      step();
      k++;
    end
    if (k >= limit) check("idle_timeout", 32'(k), 32'(0));
  endtask

  // Apply ready/clr exactly on the edge where the next byte will be captured.
  task automatic on_accept(input logic rdy, input logic clr);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (rx_rdy && !m_busy) begin
        out_ready   = rdy;
        overrun_clr = clr;
        step();
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        found       = 1'b1;
      end else begin
        step();
      end
    end
    if (!found) check("accept_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #35;
    check("rst_count", 32'(count), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_clr", 32'(rx_rdy_clr), 32'(0));
    check("rst_ovr", 32'(overrun), 32'(0));
    check("rst_dcnt", 32'(drop_count), 32'(0));
    @(posedge clk_50m);
    #1;
    rst_n = 1'b1;

    // Single byte, then pop.
    tx_q.push_back(8'hA5);
    run(4);
    check("t1_count", 32'(count), 32'(1));
    check("t1_data", 32'(out_data), 32'(8'hA5));
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    check("t1_empty", 32'(count), 32'(0));

    // Fill to DEPTH, then a drop.
    for (int i = 1; i <= DEPTH; i++) tx_q.push_back(8'(i));
    run_until_idle(100);
    check("t2_count", 32'(count), 32'(DEPTH));
    check("t2_ovr", 32'(overrun), 32'(0));
    tx_q.push_back(8'h55);
    run_until_idle(20);
    check("t3_ovr", 32'(overrun), 32'(1));
    check("t3_count", 32'(count), 32'(DEPTH));
    overrun_clr = 1'b1;
    run(1);
    overrun_clr = 1'b0;
    check("t3_clr", 32'(overrun), 32'(0));

    // Full FIFO, push coinciding with pop, then drain.
    tx_q.push_back(8'h66);
    on_accept(1'b1, 1'b0);
    check("t4_count", 32'(count), 32'(DEPTH));
    check("t4_ovr", 32'(overrun), 32'(0));
    out_ready = 1'b1;
    run(DEPTH + 2);
    out_ready = 1'b0;
    check("t4_last", 32'(last_pop), 32'(8'h66));

    // Back-to-back bytes: second presented in the CLEAR cycle.
    clr_cyc.delete();
    tx_q.push_back(8'h70);
    tx_q.push_back(8'h77);
    run_until_idle(20);
    check("t5_pulses", 32'(clr_cyc.size()), 32'(2));
    if (clr_cyc.size() == 2) check("t5_gap", 32'(clr_cyc[1] - clr_cyc[0]), 32'(2));
    check("t5_count", 32'(count), 32'(2));
    out_ready = 1'b1;
    run(3);
    out_ready = 1'b0;

    // Mid-stream asynchronous reset.
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    run_until_idle(20);
    #5;
    rst_n = 1'b0;
    #1;
    model_reset();
    tx_q.delete();
    rx_rdy = 1'b0;
    check("t6_count", 32'(count), 32'(0));
    check("t6_valid", 32'(out_valid), 32'(0));
    check("t6_clr", 32'(rx_rdy_clr), 32'(0));
    @(posedge clk_50m);
    #1;
    rst_n = 1'b1;

    // 300 drops to saturate the counter.
    for (int i = 0; i < DEPTH + 300; i++) tx_q.push_back(8'($urandom));
    run_until_idle(1000);
    check("t6_sat", 32'(drop_count), 32'(exp_dc()));
    overrun_clr = 1'b1;
    run(1);
    overrun_clr = 1'b0;
    check("t6_clr_ovr", 32'(overrun), 32'(0));
    tx_q.push_back(8'hC3);
    on_accept(1'b0, 1'b1);
    check("t6_set_wins", 32'(overrun), 32'(1));
    run(2);

    // Randomised traffic.
    gap_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (tx_q.size() < 2) tx_q.push_back(8'($urandom));
      out_ready   = (i < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 30) == 0);
      step();
    end
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    run_until_idle(100);
    run(DEPTH + 2);
    check("final_empty", 32'(count), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the 16x-oversampling UART receiver. It watches the receiver's rdy/data pair and captures each completed byte into a first-word-fall-through (FWFT) FIFO. It pulses the receiver's rdy_clr to release the receiver, presents bytes to the consumer on a valid/ready interface, and flags bytes lost to overflow. It sits between the receiver and the bus/host logic, in the clk_50m domain.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of 2, >= 2.
CW, $clog2(DEPTH)+1, occupancy count width (derived, not overridden).

Ports:
clk_50m  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx_rdy  input  1  receiver byte-ready flag.
rx_data  input  8  receiver byte; valid while rx_rdy=1.
rx_rdy_clr  output  1  one-cycle pulse to the receiver's rdy_clr.
out_data  output  8  head-of-FIFO byte.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts; pop when out_valid && out_ready.
count  output  CW  FIFO occupancy, 0..DEPTH.
overrun  output  1  sticky flag: at least one byte dropped.
overrun_clr  input  1  clears overrun (and drop_count) on the next edge.
drop_count  output  8  dropped-byte counter (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; pointers and count=0.
  - rx_rdy_clr=0, out_valid=0, overrun=0, drop_count=0.
  - out_data is don't-care while out_valid=0.
  - Reset mid-transfer discards the FIFO contents. If rx_rdy is still high after release, that byte is captured normally.
- Two-state FSM, registered outputs:
  - IDLE: when rx_rdy=1, take the byte (push, or drop if full). Set rx_rdy_clr<=1 and go to CLEAR. Otherwise stay in IDLE with rx_rdy_clr<=0.
  - CLEAR: rx_rdy_clr<=0 and go to IDLE. rx_rdy is ignored in this state, because the receiver drops rdy on this edge.
  - Result: rx_rdy_clr is high for exactly one cycle per byte. At most one byte is accepted every 2 cycles, well above the line rate.
  - If the receiver completes a new byte on the same edge it sees rdy_clr, its rdy stays 1. IDLE then captures that new byte on the following cycle; nothing is lost.
- Push:
  - Write rx_data at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - Allowed when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge.
- Drop: an IDLE capture with count==DEPTH and no pop:
  - no write;
  - overrun<=1;
  - rx_rdy_clr is still pulsed, so the receiver is never left holding stale data.
- Pop: on out_valid && out_ready, rd_ptr increments and wraps modulo DEPTH.
- Latency: a pushed byte appears on out_valid/out_data the cycle after the push edge.
- Count update per edge: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop. Never exceeds DEPTH and never underflows.
- out_valid = (count != 0). out_data = mem[rd_ptr]. Both derive from registers; there is no combinational path from rx_* to out_*.
- out_ready with out_valid=0 is ignored.
- overrun_clr:
  - clears overrun and drop_count on the next edge;
  - if a drop occurs on that same edge, set wins (overrun=1, drop_count=1).

Optional Feature:
Macro UART_RX_CTRL_DROPCNT_EN.
- Defined: drop_count increments on each drop and saturates at 255; it is cleared by overrun_clr or reset.
- Undefined: drop_count is tied to 8'd0 and no counter logic is built. The port list is identical in both builds; overrun behaviour is unchanged.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W=8;
  - the rx_ctrl state enum {IDLE, CLEAR};
  - DROP_CNT_W=8 and its saturation max constant.
- One sub-module, uart_rx_fifo: a parameterised FWFT synchronous FIFO (DEPTH, width), with push/pop/full/empty/count.
- uart_rx_ctrl owns the FSM, the drop/overrun logic and the optional counter.

Test Plan:
1. Reset with rx_rdy=0, then one byte 0xA5 (rx_rdy held until rx_rdy_clr) -> exactly one rx_rdy_clr pulse 1 cycle after rx_rdy rises. Next cycle: out_valid=1, out_data=0xA5, count=1. Pop -> count=0.
2. Stream 0x01..0x08 with out_ready=0 (DEPTH=8) -> count=8, no overrun. Then drain -> bytes emerge in order 0x01..0x08 and the pointers wrap correctly.
3. With the FIFO full and out_ready=0, deliver 0x55 -> rx_rdy_clr pulsed, byte dropped, overrun=1, count stays 8. With the macro defined, drop_count=1; undefined, drop_count=0.
4. With the FIFO full, deliver 0x66 on the same cycle as a pop -> byte accepted, count stays 8, overrun stays 0, and 0x66 is the last byte out.
5. Receiver reasserts rx_rdy with 0x77 in the CLEAR cycle -> second rx_rdy_clr pulse 2 cycles after the first, both bytes stored.
6. Assert rst_n low mid-stream with count=3 -> outputs are immediately 0 and count=0. After release, 300 drops with DROPCNT_EN -> drop_count saturates at 255. overrun_clr together with a new drop -> overrun=1, drop_count=1.
